// File: rtl/reg_req_encoder.sv
// Collects per-register request bits into a pending set and serialises them as 3-bit addresses over valid/ready.
// Optional macro REG_ENC_ROUND_ROBIN_EN selects round-robin arbitration; without it the lowest address wins.
module reg_req_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [7:0] req_mask,
  output logic       addr_valid,
  input  logic       addr_ready,
  output logic [2:0] addr_out,
  output logic [7:0] pending,
  output logic [7:0] grant_count,
  output logic       busy,
  output logic       state_dbg
);

  // Handshake: a transfer happens on any rising edge where addr_valid && addr_ready;
  // addr_out/addr_valid hold steady until then, and addr_ready without addr_valid is ignored.
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t     state;
  logic       fire;
  logic [7:0] clr;
  logic [7:0] remaining;
  logic [7:0] pending_next;
  logic [2:0] sel;

  // Mask bit 7 is r0, so address a lives at bit (7 - a).
  function automatic logic [2:0] pick(input logic [7:0] m, input logic [2:0] start);
    logic [2:0] a;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = start + 3'(i);
      if (!found && m[3'd7 - a]) begin
        pick  = a;
        found = 1'b1;
      end
    end
  endfunction

  assign fire = addr_valid && addr_ready;

  always_comb begin
    clr = 8'h00;
    if (fire) clr[3'd7 - addr_out] = 1'b1;
  end

  // New requests join after the clear, so a same-cycle set survives, but they are
  // not candidates for the selection made on this edge.
  assign remaining    = pending & ~clr;
  assign pending_next = remaining | (req_valid ? req_mask : 8'h00);

`ifdef REG_ENC_ROUND_ROBIN_EN
  logic [2:0] ptr;
  assign sel = pick(remaining, ptr);
`else
  assign sel = pick(remaining, 3'd0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= 8'h00;
      addr_valid  <= 1'b0;
      addr_out    <= 3'd0;
      grant_count <= 8'h00;
`ifdef REG_ENC_ROUND_ROBIN_EN
      ptr         <= 3'd0;
`endif
    end else begin
      pending <= pending_next;
      case (state)
        IDLE: begin
          if (pending != 8'h00) begin
            addr_out   <= sel;
            addr_valid <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (fire) begin
            grant_count <= grant_count + 8'd1;
`ifdef REG_ENC_ROUND_ROBIN_EN
            ptr         <= addr_out + 3'd1;
`endif
            if (remaining != 8'h00) begin
              addr_out <= sel;
            end else begin
              addr_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign busy      = (state != IDLE) || (pending != 8'h00);
  assign state_dbg = (state == OFFER);

endmodule

// File: tb/tb_reg_req_encoder.sv
// Directed bench for reg_req_encoder; grant addresses are scoreboarded through an expected queue.
// Arbitration expectations follow REG_ENC_ROUND_ROBIN_EN when the same macro is defined for the bench.
module tb_reg_req_encoder;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_mask;
  logic       addr_valid;
  logic       addr_ready;
  logic [2:0] addr_out;
  logic [7:0] pending;
  logic [7:0] grant_count;
  logic       busy;
  logic       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_grants = 0;
  logic [2:0] exp_q[$];

  reg_req_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_mask    (req_mask),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .addr_out    (addr_out),
    .pending     (pending),
    .grant_count (grant_count),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [2:0] a);
    exp_q.push_back(a);
    exp_grants++;
  endtask

  task automatic request(input logic [7:0] m);
    req_valid = 1'b1;
    req_mask  = m;
    tick();
    req_valid = 1'b0;
    req_mask  = 8'h00;
  endtask

  // scoreboard: inputs are stable at the falling edge, so a handshake seen here completes on the next rise
  always @(negedge clk) begin
    if (rst_n && addr_valid && addr_ready) begin
      if (exp_q.size() == 0) check("grant_unexpected", 32'(addr_out), 32'hFFFF_FFFF);
      else check("grant_addr", 32'(addr_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int v_cnt;
    logic [7:0] m;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_mask   = 8'h00;
    addr_ready = 1'b0;
    tick();
    tick();
    check("rst_valid",   32'(addr_valid),  32'd0);
    check("rst_addr",    32'(addr_out),    32'd0);
    check("rst_pending", 32'(pending),     32'd0);
    check("rst_count",   32'(grant_count), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_state",   32'(state_dbg),   32'd0);
    rst_n = 1'b1;
    tick();

    // single request r2, two-cycle latency, one-cycle offer
    addr_ready = 1'b1;
    expect_grant(3'd2);
    request(8'b0010_0000);
    check("single_pend", 32'(pending),    32'h20);
    check("single_v0",   32'(addr_valid), 32'd0);
    tick();
    check("single_v1",   32'(addr_valid), 32'd1);
    check("single_addr", 32'(addr_out),   32'd2);
    tick();
    check("single_v2",    32'(addr_valid),  32'd0);
    check("single_clear", 32'(pending),     32'd0);
    check("single_count", 32'(grant_count), 32'd1);
    check("single_busy",  32'(busy),        32'd0);

    // arbitration: grant r5, then r0/r6/r7 together
    expect_grant(3'd5);
    request(8'b0000_0100);
    tick();
    tick();
`ifdef REG_ENC_ROUND_ROBIN_EN
    expect_grant(3'd6); expect_grant(3'd7); expect_grant(3'd0);
`else
    expect_grant(3'd0); expect_grant(3'd6); expect_grant(3'd7);
`endif
    request(8'b1000_0011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arb_valid", 32'(addr_valid), 32'd1);
    end
    tick();
    check("arb_done_v", 32'(addr_valid),  32'd0);
    check("arb_count",  32'(grant_count), 32'(8'(exp_grants)));

    // backpressure: r3 held under stall, r1 arrives mid-stall
    addr_ready = 1'b0;
    expect_grant(3'd3);
    expect_grant(3'd1);
    request(8'b0001_0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(addr_valid), 32'd1);
      check("bp_addr",  32'(addr_out),   32'd3);
      req_valid = (i == 1);
      req_mask  = (i == 1) ? 8'b0100_0000 : 8'h00;
      tick();
    end
    req_valid = 1'b0;
    req_mask  = 8'h00;
    check("bp_pend", 32'(pending), 32'h50);
    addr_ready = 1'b1;
    tick();
    check("bp_next", 32'(addr_out), 32'd1);
    tick();
    check("bp_done_v", 32'(addr_valid),  32'd0);
    check("bp_count",  32'(grant_count), 32'(8'(exp_grants)));

    // collision: r4 re-requested on its own handshake edge
    expect_grant(3'd4);
    expect_grant(3'd4);
    request(8'b0000_1000);
    tick();
    check("col_addr", 32'(addr_out), 32'd4);
    request(8'b0000_1000);
    check("col_pend", 32'(pending),    32'h08);
    check("col_v",    32'(addr_valid), 32'd0);
    tick();
    check("col_regrant", 32'(addr_out),   32'd4);
    check("col_regrant_v", 32'(addr_valid), 32'd1);
    tick();
    check("col_clear", 32'(pending), 32'd0);

    // all eight pending: back-to-back grants with no bubble
`ifdef REG_ENC_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) expect_grant(3'(5 + i));
`else
    for (int i = 0; i < 8; i++) expect_grant(3'(i));
`endif
    request(8'hFF);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("all8_valid", 32'(addr_valid), 32'd1);
      tick();
    end
    check("all8_done_v", 32'(addr_valid),  32'd0);
    check("all8_pend",   32'(pending),     32'd0);
    check("all8_count",  32'(grant_count), 32'(8'(exp_grants)));

    // empty mask has no effect
    request(8'h00);
    tick();
    check("zero_pend", 32'(pending),    32'd0);
    check("zero_v",    32'(addr_valid), 32'd0);
    check("zero_busy", 32'(busy),       32'd0);

    // reset mid-offer with everything pending
    addr_ready = 1'b0;
    request(8'hFF);
    tick();
    tick();
    check("mid_v", 32'(addr_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_grants = 0;
    check("mrst_valid",   32'(addr_valid),  32'd0);
    check("mrst_addr",    32'(addr_out),    32'd0);
    check("mrst_pending", 32'(pending),     32'd0);
    check("mrst_count",   32'(grant_count), 32'd0);
    check("mrst_busy",    32'(busy),        32'd0);
    addr_ready = 1'b1;
    tick();
    check("idle_ready_v",     32'(addr_valid),  32'd0);
    check("idle_ready_count", 32'(grant_count), 32'd0);

    // counter wrap over 256 single grants
    v_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      m = 8'h80 >> (i % 8);
      expect_grant(3'(i % 8));
      request(m);
      v_cnt += int'(addr_valid);
      tick();
      v_cnt += int'(addr_valid);
      tick();
      v_cnt += int'(addr_valid);
      if (i == 254) check("wrap_255", 32'(grant_count), 32'd255);
    end
    check("wrap_vcnt",  v_cnt,              256);
    check("wrap_count", 32'(grant_count),   32'd0);
    check("wrap_v",     32'(addr_valid),    32'd0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
